vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives DrawX, DrawY and blank into every sprite/background renderer (start screen, office, camera views).
- Drives hs and vs to the VGA/HDMI output stage.
- Also supplies a per-frame strobe and a wrapping frame counter, which game logic uses for animation and timers.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
FC_WIDTH, 8, width of frame_count

Ports:
vga_clk  input  1  pixel clock, 25 MHz; all logic on posedge
reset  input  1  synchronous, active-high
DrawX  output  10  current horizontal count, 0..H_TOTAL-1
DrawY  output  10  current vertical count, 0..V_TOTAL-1
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
blank  output  1  1 = visible region (draw enable), 0 = blanking
frame_start  output  1  one-cycle pulse at position (0,0)
frame_count  output  FC_WIDTH  frames since reset, wraps

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = 525.
- Internal hc, vc (10 bits) are registered. DrawX = hc and DrawY = vc directly.
- Every other output is a registered decode of the next (hc, vc), so all outputs change on the same edge as DrawX/DrawY. Output skew relative to DrawX/DrawY is 0 cycles.
- Counting:
  - hc increments each cycle; at hc = H_TOTAL-1 it wraps to 0 and vc advances.
  - vc wraps to 0 after V_TOTAL-1 when hc wraps.
  - hc and vc never hold values of H_TOTAL/V_TOTAL or above.
- Decodes, all against the same (hc, vc):
  - hs = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. vs covers whole lines, hc 0..799.
  - blank = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
  - DrawX/DrawY keep counting through blanking. Consumers must gate on blank and must not treat DrawX > 639 as an error.
  - frame_start = 1 for exactly the cycle where hc = 0 and vc = 0, except the reset cycle itself.
- frame_count increments by 1 on each transition into (0,0) from (H_TOTAL-1, V_TOTAL-1). It wraps from 2^FC_WIDTH-1 to 0.
- Reset values, held while reset = 1:
  - DrawX = 0, DrawY = 0, hs = 1, vs = 1, blank = 1 (consistent with position 0,0), frame_start = 0, frame_count = 0.
  - The first edge after release produces DrawX = 1, DrawY = 0.
  - Reset mid-frame returns to these values on the next edge with no partial sync pulse. Any hs/vs low is terminated immediately.
- Consumer timing contract:
  - DrawX/DrawY are stable from posedge to posedge.
  - Renderers may issue ROM reads on negedge and register colour on the following posedge. The resulting one-pixel pipeline delay is accepted system-wide and is not compensated here.
- Period checks: line period is exactly 800 cycles, frame period exactly 420000 cycles.
- No handshake or backpressure exists; the block free-runs.

Test Plan:
- Reset held 5 cycles, then released -> during reset DrawX = 0, DrawY = 0, hs = 1, vs = 1, frame_count = 0, frame_start = 0. First post-release cycle gives DrawX = 1, DrawY = 0.
- Run one line from reset -> hs low for exactly 96 cycles with DrawX 656..751. blank falls when DrawX goes 639->640. DrawX wraps 799->0 and DrawY goes 0->1 on the same edge.
- Run one full frame -> vs low exactly while DrawY is 490..491 (1600 cycles). blank = 0 whenever DrawY >= 480. Next frame_start occurs 420000 cycles after release-equivalent (0,0), and frame_count becomes 1.
- Run 256 frames with FC_WIDTH = 8 -> frame_count wraps 255->0. frame_start pulses exactly 256 times, each 1 cycle wide.
- Assert reset at DrawX = 700, DrawY = 491, while hs = 0 and vs = 0 -> the next edge shows hs = 1, vs = 1, DrawX = 0, DrawY = 0 and frame_count = 0. Counting resumes cleanly after release.
- Scoreboard over 2 frames -> blank == (DrawX < 640 && DrawY < 480) on every cycle, and DrawX stays <= 799 and DrawY <= 524 throughout.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: free-running pixel/line counters plus sync, blank,
// frame strobe and frame counter, all registered so they align with DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FC_WIDTH  = 8
) (
  input  logic                vga_clk,
  input  logic                reset,
  output logic [9:0]          DrawX,
  output logic [9:0]          DrawY,
  output logic                hs,
  output logic                vs,
  output logic                blank,
  output logic                frame_start,
  output logic [FC_WIDTH-1:0] frame_count
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       line_end;
  logic       frame_end;

  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
    return (x < H_VIS) && (y < V_VIS);
  endfunction

  always_comb begin
    line_end  = (hc == H_LAST);
    frame_end = line_end && (vc == V_LAST);
    hc_next   = line_end ? 10'd0 : hc + 10'd1;
    vc_next   = vc;
    if (line_end) begin
      vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
  end

  // Outputs are decoded from the next position so they land on the same edge
  // as the counters; reset forces the position-(0,0) idle values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= 10'd0;
      vc          <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      hs          <= ~in_window(hc_next, HS_START, HS_END);
      vs          <= ~in_window(vc_next, VS_START, VS_END);
      blank       <= visible(hc_next, vc_next);
      frame_start <= frame_end;
      if (frame_end) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken
// instance for frame-level behaviour, both against a position-from-time model.
module tb_vga_timing_gen;

  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHV + SHF + SHS + SHB;  // 15
  localparam int SVT = SVV + SVF + SVS + SVB;  // 11
  localparam int SFR = SHT * SVT;              // 165

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic       hs_d, vs_d, bl_d, fs_d, hs_s, vs_s, bl_s, fs_s;
  logic [7:0] fc_d, fc_s;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #20 clk = ~clk;

  // Edges since the last reset edge; drives the reference model.
  always @(posedge clk) t <= reset ? 0 : t + 1;

  vga_timing_gen dut_full (
    .vga_clk(clk), .reset(reset), .DrawX(dx_d), .DrawY(dy_d), .hs(hs_d), .vs(vs_d),
    .blank(bl_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .FC_WIDTH(8)
  ) dut_small (
    .vga_clk(clk), .reset(reset), .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s),
    .blank(bl_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  // Expected {DrawX, DrawY, hs, vs, blank, frame_start, frame_count} after
  // `tt` edges from (0,0), derived from the raster geometry alone.
  function automatic logic [31:0] model(input int tt, input int hv, input int hf,
                                        input int hsw, input int hb, input int vv,
                                        input int vf, input int vsw, input int vb);
    int ht, vt, pos, x, y, fc;
    logic h, v, b, f;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    pos = tt % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    h   = !(x >= hv + hf && x < hv + hf + hsw);
    v   = !(y >= vv + vf && y < vv + vf + vsw);
    b   = (x < hv) && (y < vv);
    f   = (pos == 0) && (tt > 0);
    fc  = (tt / (ht * vt)) % 256;
    return {10'(x), 10'(y), h, v, b, f, 8'(fc)};
  endfunction

  function automatic logic [31:0] act_small();
    return {dx_s, dy_s, hs_s, vs_s, bl_s, fs_s, fc_s};
  endfunction

  function automatic logic [31:0] act_full();
    return {dx_d, dy_d, hs_d, vs_d, bl_d, fs_d, fc_d};
  endfunction

  function automatic logic [31:0] exp_small();
    return model(t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction

  function automatic logic [31:0] exp_full();
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rv;
    rv = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act_small() !== rv) begin
        errors++;
        $display("FAIL reset_small cycle %0d: got %h want %h", i, act_small(), rv);
      end
      checks++;
      if (act_full() !== rv) begin
        errors++;
        $display("FAIL reset_full cycle %0d: got %h want %h", i, act_full(), rv);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dx_d !== 10'd1 || dy_d !== 10'd0) begin
      errors++;
      $display("FAIL first_after_release: got X=%0d Y=%0d want X=1 Y=0", dx_d, dy_d);
    end
  endtask

  task automatic test_line();
    int hs_low;
    int hs_first;
    hs_low   = 0;
    hs_first = -1;
    restart();
    for (int i = 1; i <= 800; i++) begin
      tick();
      checks++;
      if (act_full() !== exp_full()) begin
        errors++;
        $display("FAIL line_cycle t=%0d: got %h want %h", t, act_full(), exp_full());
      end
      if (hs_d === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(dx_d);
      end
    end
    checks++;
    if (hs_low != 96 || hs_first != 656) begin
      errors++;
      $display("FAIL hs_width: got %0d cycles from X=%0d want 96 from 656", hs_low, hs_first);
    end
    checks++;
    if (dx_d !== 10'd0 || dy_d !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got X=%0d Y=%0d want X=0 Y=1", dx_d, dy_d);
    end
  endtask

  task automatic test_frame();
    int vs_low;
    vs_low = 0;
    restart();
    for (int i = 1; i <= 2 * SFR; i++) begin
      tick();
      checks++;
      if (act_small() !== exp_small()) begin
        errors++;
        $display("FAIL frame_cycle t=%0d: got %h want %h", t, act_small(), exp_small());
      end
      checks++;
      if (int'(dx_s) >= SHT || int'(dy_s) >= SVT) begin
        errors++;
        $display("FAIL bounds t=%0d: got X=%0d Y=%0d", t, dx_s, dy_s);
      end
      if (vs_s === 1'b0) vs_low++;
      if (i == SFR) begin
        checks++;
        if (fc_s !== 8'd1 || fs_s !== 1'b1) begin
          errors++;
          $display("FAIL frame_period: got fc=%0d fs=%b want fc=1 fs=1", fc_s, fs_s);
        end
      end
    end
    checks++;
    if (vs_low != 2 * SVS * SHT) begin
      errors++;
      $display("FAIL vs_width: got %0d want %0d", vs_low, 2 * SVS * SHT);
    end
  endtask

  task automatic test_fc_wrap();
    int pulses;
    int mism;
    pulses = 0;
    mism   = 0;
    restart();
    for (int i = 1; i <= 256 * SFR; i++) begin
      tick();
      checks++;
      if (act_small() !== exp_small()) begin
        errors++;
        mism++;
        if (mism <= 10) $display("FAIL wrap_cycle t=%0d: got %h want %h", t, act_small(), exp_small());
      end
      if (fs_s === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 256 || fc_s !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap: got pulses=%0d fc=%0d want 256 and 0", pulses, fc_s);
    end
  endtask

  task automatic test_mid_reset();
    int  guard;
    logic [31:0] rv;
    rv = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    guard = 0;
    restart();
    while (!(dx_s == 10'd11 && dy_s == 10'd8) && guard < 3 * SFR) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 3 * SFR || hs_s !== 1'b0 || vs_s !== 1'b0) begin
      errors++;
      $display("FAIL mid_reach: got X=%0d Y=%0d hs=%b vs=%b want 11,8,0,0", dx_s, dy_s, hs_s, vs_s);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (act_small() !== rv) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", act_small(), rv);
    end
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (act_small() !== exp_small()) begin
        errors++;
        $display("FAIL resume t=%0d: got %h want %h", t, act_small(), exp_small());
      end
    end
  endtask

  task automatic test_random_reset();
    int n, r;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 400));
      r = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        tick();
        checks++;
        if (act_small() !== exp_small()) begin
          errors++;
          $display("FAIL rand_small t=%0d: got %h want %h", t, act_small(), exp_small());
        end
        checks++;
        if (act_full() !== exp_full()) begin
          errors++;
          $display("FAIL rand_full t=%0d: got %h want %h", t, act_full(), exp_full());
        end
      end
      reset = 1'b1;
      for (int i = 0; i < r; i++) begin
        tick();
        checks++;
        if (act_small() !== exp_small() || act_full() !== exp_full()) begin
          errors++;
          $display("FAIL rand_reset: got %h/%h want %h/%h", act_small(), act_full(),
                   exp_small(), exp_full());
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_fc_wrap();
    test_mid_reset();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
